// File: rtl/hash_engine_if.sv
// Memory-side bus of hash_engine: write port 1 carries hash words,
// read port 2 returns pixels RD_LAT cycles after the address.
interface hash_engine_if #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32,
  parameter int PIX_W  = 32
);
  logic [ADDR_W-1:0] hash_A1;
  logic [WORD_W-1:0] hash_I1;
  logic              hash_WEB1;
  logic [ADDR_W-1:0] hash_A2;
  logic              hash_WEB2;
  logic [PIX_W-1:0]  hash_O2;

  modport master (
    output hash_A1,
    output hash_I1,
    output hash_WEB1,
    output hash_A2,
    output hash_WEB2,
    input  hash_O2
  );

  modport slave (
    input  hash_A1,
    input  hash_I1,
    input  hash_WEB1,
    input  hash_A2,
    input  hash_WEB2,
    output hash_O2
  );
endinterface

// File: rtl/hash_engine.sv
// Average / difference image hash: reads N_PIX pixels, thresholds each
// into one bit, writes WORD_W-bit hash words and pulses done.
// Ports: clk, reset (async, active-high); start/mode/image_idx/sum
// request inputs; busy/done/hash_value status; mem = memory bus.
module hash_engine #(
  parameter int N_PIX     = 256,
  parameter int PIX_W     = 32,
  parameter int WORD_W    = 32,
  parameter int SUM_W     = 16,
  parameter int ADDR_W    = 12,
  parameter int PIX_BASE  = 0,
  parameter int HASH_BASE = 256,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [8:0]       image_idx,
  input  logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic [N_PIX-1:0] hash_value,
  hash_engine_if.master    mem
);

  localparam int LOGN   = $clog2(N_PIX);
  localparam int LOGW   = $clog2(WORD_W);
  localparam int CW     = (PIX_W > SUM_W) ? PIX_W : SUM_W;
  localparam int NWORDS = N_PIX / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              mode_q;
  logic [8:0]        idx_q;
  logic [CW-1:0]     mean_q;
  logic [CW-1:0]     prev_q;
  logic [LOGN-1:0]   rcnt;
  logic [LOGN-1:0]   bcnt;
  logic [RD_LAT-1:0] vld;
  logic [WORD_W-2:0] sh;
  logic              fin;

  logic              accept;
  logic              run;
  logic              rd_last;
  logic              cap;
  logic              bit_v;
  logic              word_end;
  logic              bit_last;
  logic [CW-1:0]     pix_c;
  logic [SUM_W-1:0]  mean_in;
  logic [ADDR_W-1:0] wr_addr;

  assign accept   = (state == IDLE) && start;
  assign run      = (state == RUN);
  assign rd_last  = (rcnt == LOGN'(N_PIX - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign mean_in  = sum >> LOGN;

  // vld tracks reads in flight; its oldest stage marks a pixel
  // arriving on hash_O2 this cycle.
  assign cap      = vld[RD_LAT-1];
  assign pix_c    = CW'(mem.hash_O2);
  assign bit_v    = mode_q ? (pix_c > prev_q)
                           : (pix_c >= mean_q);
  assign word_end = (bcnt[LOGW-1:0] == {LOGW{1'b1}});
  assign bit_last = (bcnt == LOGN'(N_PIX - 1));
  assign wr_addr  = ADDR_W'(HASH_BASE)
                  + ADDR_W'(idx_q) * ADDR_W'(NWORDS)
                  + ADDR_W'(bcnt >> LOGW);

  assign mem.hash_WEB2 = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (rd_last) state_nx = FLUSH;
      FLUSH:   if (fin) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= 1'b0;
      idx_q         <= '0;
      mean_q        <= '0;
      prev_q        <= '0;
      rcnt          <= '0;
      bcnt          <= '0;
      vld           <= '0;
      sh            <= '0;
      fin           <= 1'b0;
      hash_value    <= '0;
      mem.hash_WEB1 <= 1'b1;
      mem.hash_A1   <= '0;
      mem.hash_I1   <= '0;
      mem.hash_A2   <= '0;
    end else begin
      mem.hash_WEB1 <= 1'b1;
      vld           <= RD_LAT'({vld, run});
      if (accept) begin
        mode_q      <= mode;
        idx_q       <= image_idx;
        mean_q      <= CW'(mean_in);
        prev_q      <= CW'(mean_in);
        rcnt        <= '0;
        bcnt        <= '0;
        fin         <= 1'b0;
        hash_value  <= '0;
        mem.hash_A2 <= ADDR_W'(PIX_BASE);
      end
      if (run && !rd_last) begin
        rcnt        <= rcnt + 1'b1;
        mem.hash_A2 <= ADDR_W'(PIX_BASE)
                     + ADDR_W'(rcnt) + ADDR_W'(1);
      end
      if (cap) begin
        hash_value[bcnt] <= bit_v;
        prev_q           <= pix_c;
        sh               <= {bit_v, sh[WORD_W-2:1]};
        bcnt             <= bcnt + 1'b1;
        // The word completes with this bit; sh holds the
        // lower WORD_W-1 bits captured before it.
        if (word_end) begin
          mem.hash_WEB1 <= 1'b0;
          mem.hash_A1   <= wr_addr;
          mem.hash_I1   <= {bit_v, sh};
        end
        if (bit_last) fin <= 1'b1;
      end
    end
  end

endmodule
